// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared types for the instruction/data memory arbiter.
//   state_t : arbiter sequencing states
//   owner_t : which requester owns the outstanding memory transaction
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_RSP = 2'd2,
    RESP     = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   One request/grant/response memory channel. The same bundle describes
//   the fetch port, the load/store port and the shared memory port.
//   master : issues requests (drives req/we/addr/wdata/be), receives gnt/rvalid/rdata
//   slave  : accepts requests (drives gnt/rvalid/rdata)
//   Ports:
//     req    request, held until gnt
//     we     1 = write
//     addr   byte address
//     wdata  write data
//     be     write byte enables
//     gnt    request accepted
//     rvalid response valid (reads and writes)
//     rdata  read data
interface mem_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 16
) ();

  logic                      req;
  logic                      we;
  logic [ADDRESS_WIDTH-1:0]  addr;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   be;
  logic                      gnt;
  logic                      rvalid;
  logic [DATA_WIDTH-1:0]     rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-ported memory between instruction fetch and load/store.
//   One transaction is outstanding at a time; data has priority, but after
//   STARVE_LIMIT consecutive data grants with fetch waiting, fetch wins.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | no transaction; grant a requester combinationally
//   WAIT_GNT | mem_req asserted with latched fields, waiting for mem_gnt
//   WAIT_RSP | memory accepted, waiting for mem_rvalid
//   RESP     | owner's rvalid/rdata presented for one cycle
//
//   Ports:
//     clk      clock
//     rst      synchronous, active-high reset
//     if_bus   fetch requester (we/wdata/be ignored: fetches are reads)
//     d_bus    load/store requester
//     mem_bus  shared memory port
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 16,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   if_bus,
  mem_arbiter_if.slave   d_bus,
  mem_arbiter_if.master  mem_bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  state_t                    state;
  owner_t                    owner;
  logic [CNT_W-1:0]          starve_cnt;

  logic                      lat_we;
  logic [ADDRESS_WIDTH-1:0]  lat_addr;
  logic [DATA_WIDTH-1:0]     lat_wdata;
  logic [DATA_WIDTH/8-1:0]   lat_be;
  logic                      mem_req_q;

  logic                      if_rvalid_q;
  logic                      d_rvalid_q;
  logic [DATA_WIDTH-1:0]     if_rdata_q;
  logic [DATA_WIDTH-1:0]     d_rdata_q;

  logic                      fetch_turn;
  logic                      if_gnt_c;
  logic                      d_gnt_c;
  logic                      rsp_take;
  logic                      unused_fetch_fields;

  // Fetch is a read-only requester; its write-side fields are never used.
  assign unused_fetch_fields = ^{if_bus.we, if_bus.wdata, if_bus.be};

  assign fetch_turn = if_bus.req && (starve_cnt == CNT_MAX);

  // Grants are combinational so a request seen in IDLE is accepted that cycle.
  // Gated by rst so nothing is handed out while a reset is being applied.
  assign if_gnt_c = (state == IDLE) && !rst && if_bus.req && (!d_bus.req || fetch_turn);
  assign d_gnt_c  = (state == IDLE) && !rst && d_bus.req && !fetch_turn;

  // A response is only meaningful once memory has accepted (or is accepting)
  // our request; mem_rvalid in any other state is dropped.
  assign rsp_take = mem_bus.rvalid &&
                    (((state == WAIT_GNT) && mem_bus.gnt) || (state == WAIT_RSP));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= OWN_IF;
      starve_cnt  <= '0;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_be      <= '0;
      mem_req_q   <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;

      if (rsp_take) begin
        if (owner == OWN_IF) begin
          if_rvalid_q <= 1'b1;
          if_rdata_q  <= mem_bus.rdata;
        end else begin
          d_rvalid_q <= 1'b1;
          d_rdata_q  <= lat_we ? '0 : mem_bus.rdata;
        end
      end

      case (state)
        IDLE: begin
          if (if_gnt_c) begin
            owner      <= OWN_IF;
            lat_we     <= 1'b0;
            lat_addr   <= if_bus.addr;
            lat_wdata  <= '0;
            lat_be     <= '1;
            mem_req_q  <= 1'b1;
            starve_cnt <= '0;
            state      <= WAIT_GNT;
          end else if (d_gnt_c) begin
            owner      <= OWN_D;
            lat_we     <= d_bus.we;
            lat_addr   <= d_bus.addr;
            lat_wdata  <= d_bus.wdata;
            lat_be     <= d_bus.be;
            mem_req_q  <= 1'b1;
            if (!if_bus.req)
              starve_cnt <= '0;
            else if (starve_cnt != CNT_MAX)
              starve_cnt <= starve_cnt + 1'b1;
            state      <= WAIT_GNT;
          end else if (!if_bus.req) begin
            starve_cnt <= '0;
          end
        end
        WAIT_GNT: begin
          if (mem_bus.gnt) begin
            mem_req_q <= 1'b0;
            state     <= mem_bus.rvalid ? RESP : WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (mem_bus.rvalid)
            state <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign if_bus.gnt    = if_gnt_c;
  assign if_bus.rvalid = if_rvalid_q;
  assign if_bus.rdata  = if_rdata_q;

  assign d_bus.gnt     = d_gnt_c;
  assign d_bus.rvalid  = d_rvalid_q;
  assign d_bus.rdata   = d_rdata_q;

  assign mem_bus.req   = mem_req_q;
  assign mem_bus.we    = lat_we;
  assign mem_bus.addr  = lat_addr;
  assign mem_bus.wdata = lat_wdata;
  assign mem_bus.be    = lat_be;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential arbiter sharing one single-ported unified memory between the instruction-fetch path and the load/store path of the RV32 core. Accepts independent request/grant handshakes from both requesters, forwards one transaction at a time to the memory port, tracks the single outstanding access and routes the response back to its owner. Fixed priority favours data, with a starvation limit so fetch always progresses.

## Interface
- DATA_WIDTH, 32, memory word width
- ADDRESS_WIDTH, 16, byte address width
- STARVE_LIMIT, 4, max consecutive data grants while fetch waits
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  ADDRESS_WIDTH  fetch address
- if_gnt  out  1  fetch request accepted (1-cycle pulse)
- if_rvalid  out  1  fetch data valid (1-cycle pulse)
- if_rdata  out  DATA_WIDTH  fetched instruction
- d_req  in  1  load/store request, held until d_gnt
- d_we  in  1  1 = store
- d_addr  in  ADDRESS_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_be  in  DATA_WIDTH/8  store byte enables
- d_gnt  out  1  data request accepted (1-cycle pulse)
- d_rvalid  out  1  load data / store ack valid (1-cycle pulse)
- d_rdata  out  DATA_WIDTH  load data (0 on store ack)
- mem_req  out  1  memory request
- mem_we, mem_addr, mem_wdata, mem_be  out  1/AW/DW/DW/8  latched transaction
- mem_gnt  in  1  memory accepted request
- mem_rvalid  in  1  memory response valid (reads and writes)
- mem_rdata  in  DATA_WIDTH  memory read data

## Operation
- States: IDLE, WAIT_GNT, WAIT_RSP, RESP.
- IDLE: if any request, pick winner, pulse its gnt, latch addr/we/wdata/be and owner into registers, go WAIT_GNT. Fetch requests latch we=0, be=all ones.
- Arbitration: d_req wins unless if_req=1 and starve_cnt==STARVE_LIMIT, then fetch wins.
- starve_cnt: +1 on each data grant while if_req=1; cleared on fetch grant or when if_req=0 in IDLE; saturates at STARVE_LIMIT.
- WAIT_GNT: mem_req=1 with latched fields held stable; on mem_gnt go WAIT_RSP, or directly RESP if mem_rvalid also 1 same cycle.
- WAIT_RSP: wait for mem_rvalid; capture mem_rdata, go RESP.
- RESP: pulse owner's rvalid with captured data (d_rdata forced 0 for stores); go IDLE.
- Exactly one outstanding transaction; no new grant outside IDLE.
- mem_rvalid outside WAIT_GNT/WAIT_RSP ignored.
- Address bits passed through unmodified; no alignment check.

## Timing
- Reset: state IDLE, starve_cnt 0, all gnt/rvalid/mem_req 0, rdata outputs 0, latched fields 0.
- Request seen cycle 0 -> gnt cycle 0 (combinational from IDLE + req) -> mem_req cycle 1 -> earliest mem_gnt+mem_rvalid cycle 1 -> rvalid cycle 2. Min turnaround 3 cycles; next grant earliest cycle 3.
- Outputs mem_* registered (from latched fields + state); rvalid/rdata registered.
- Simultaneous if_req and d_req in IDLE: one grant only, other request stays pending.
- rst mid-transaction: abort to IDLE next edge, no rvalid issued; late mem_rvalid after reset ignored.
- Requester dropping req after gnt is legal; dropping before gnt simply withdraws.

## Structure
- Package mem_arbiter_pkg: state enum (IDLE, WAIT_GNT, WAIT_RSP, RESP), owner enum (OWN_IF, OWN_D).
- Single module, no sub-module; starve counter inline.

## Test plan
- Single fetch if_addr=0x0010, memory gnt same cycle, rvalid 1 cycle later with 0x00500093 -> if_gnt cycle 0, if_rvalid cycle 3, if_rdata=0x00500093, d_rvalid never.
- Store d_addr=0x0100, d_wdata=0xDEADBEEF, d_be=4'b1111, mem_gnt delayed 3 cycles -> mem_* fields stable throughout, d_rvalid once with d_rdata=0.
- Both requesters continuously active, STARVE_LIMIT=4 -> grant sequence D,D,D,D,IF repeating.
- mem_gnt and mem_rvalid same cycle with rdata 0x12345678 -> goes straight to RESP, owner rvalid next cycle with 0x12345678.
- rst asserted in WAIT_RSP, then mem_rvalid pulse -> no rvalid to either requester, state IDLE, mem_req 0.
- Spurious mem_rvalid while IDLE -> no outputs change.
